fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Parametrised next-generation forwarding and hazard controller for the pipelined MIPS core.
- Selects bypass sources for NSRC EX-stage operands from NFWD producer stages. Detects load-use hazards and inserts one bubble.
- Freezes the pipeline while the data cache signals a miss, and flags misses that exceed a timeout.
- Sits between the pipeline latches and the hazard/stall inputs of each latch.

Parameters:
- NSRC, 2, consumer operands per instruction (rs, rt, ...).
- NFWD, 2, producer stages; index 0 is the youngest (MEM), NFWD-1 the oldest (WB).
- REGW, 5, register index width.
- SELW, $clog2(NFWD+1), forward-select width.
- MISS_TIMEOUT, 255, miss cycles before the timeout flag sets.
- CNTW, 32, statistics counter width.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset.
- src_ex  in  NSRC*REGW  EX-stage source registers; slice i is operand i.
- src_used_ex  in  NSRC  operand i is actually read.
- src_id  in  NSRC*REGW  ID-stage source registers.
- src_used_id  in  NSRC  ID operand i is actually read.
- dst_stage  in  NFWD*REGW  destination register of each producer stage.
- wr_stage  in  NFWD  RegWr of each producer stage.
- memrd_ex  in  1  EX instruction is a load.
- dst_ex  in  REGW  EX destination register.
- dmem_wait  in  1  MEM access pending without dhit.
- fwd_sel  out  NSRC*SELW  0 = register file; k = stage k-1.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_id_ex  out  1  clear ID/EX.
- freeze_all  out  1  hold every pipeline latch.
- miss_timeout  out  1  sticky flag.
- fwd_count, lu_count, miss_count  out  CNTW each  statistics counters.

Behaviour:
- Match(i,k): wr_stage[k], dst_stage[k]!=0, src_used_ex[i], and dst_stage[k]==src_ex[i].
- Live select for operand i is k+1 for the lowest matching k; it is 0 if nothing matches.
- lu_hazard: memrd_ex, dst_ex!=0, and there exists i with src_used_id[i] and src_id[i]==dst_ex.
- The FSM has three states: RUN, MISS, RESUME. It resets to RUN.
- RUN:
  - fwd_sel is the live select.
  - freeze_all = dmem_wait.
  - If lu_hazard && !dmem_wait: stall_if_id=1 and bubble_id_ex=1 in the same cycle (zero latency).
  - dmem_wait moves the state to MISS and records the live fwd_sel into a hold register.
- MISS:
  - freeze_all=1. stall_if_id and bubble_id_ex are 0; no load-use bubble is issued while frozen.
  - fwd_sel drives the hold register.
  - The miss counter increments every cycle, saturating.
  - When it reaches MISS_TIMEOUT, miss_timeout sets and stays set until RST.
  - !dmem_wait moves the state to RESUME and clears the miss counter.
- RESUME (one cycle):
  - Same as RUN: live fwd_sel, load-use detection re-evaluated.
  - dmem_wait moves the state back to MISS. Otherwise it moves to RUN.
- RUN entry with dmem_wait in the first cycle: freeze_all is asserted combinationally that same cycle.
- RST in any state: state RUN, hold register 0, miss counter 0, miss_timeout 0, statistics counters 0.
- Reset values of outputs: fwd_sel=0, stall_if_id=0, bubble_id_ex=0, freeze_all=0.
- Reset mid-MISS takes effect at the next edge and must not wait for dmem_wait to fall.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, three counters are kept:
  - fwd_count increments once per cycle in which any fwd_sel slice is non-zero and freeze_all=0.
  - lu_count increments per inserted bubble.
  - miss_count increments per MISS cycle.
  - All three saturate at all-ones and clear on RST.
- When undefined, the counter logic is absent and the three ports are tied to 0.

Decomposition:
- Add to cpu_types_pkg:
  - fhc_state_t enum {RUN, MISS, RESUME}.
  - FHC_SEL_RF = 0 localparam.
- Sub-module fwd_select: purely combinational priority match for one operand, instantiated NSRC times via generate.
- The FSM, the hold register, the timeout logic and the counters stay in the top module.

Test Plan:
- NSRC=2, NFWD=2. MEM writes $5, WB writes $5, src_ex[0]=$5 -> fwd_sel[0]=1. WB alone writing $5 -> fwd_sel[0]=2.
- Destination $0 with wr_stage=1, or src_used_ex=0 -> fwd_sel=0.
- memrd_ex=1, dst_ex=$8, src_id[1]=$8, src_used_id[1]=1 -> stall_if_id=1 and bubble_id_ex=1 for exactly one cycle. lu_count=1 with the macro.
- dmem_wait high for 4 cycles while fwd_sel[0]=1; producer inputs changed mid-miss:
  - fwd_sel stays 1 and freeze_all=1 for all 4 cycles.
  - Next cycle is RESUME with the live select.
  - miss_count=4.
- MISS_TIMEOUT=3, dmem_wait held 5 cycles -> miss_timeout rises in the 4th MISS cycle and stays high after dmem_wait falls, until RST.
- RST pulsed during MISS -> next cycle state RUN, freeze_all follows dmem_wait, all counters 0, miss_timeout 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared pipeline control types; forwarding/hazard controller items.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MISS   = 2'd1,
      RESUME = 2'd2
   } fhc_state_t;

   // Forward-select code meaning "take the operand from the register file"
   localparam int FHC_SEL_RF = 0;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module : fwd_select
// Brief  : Priority bypass-source match for one EX operand (youngest wins).
// Rev    : 1.0  initial release
// ============================================================================
module fwd_select
   import cpu_types_pkg::*;
#(
   parameter int NFWD = 2,
   parameter int REGW = 5,
   parameter int SELW = $clog2(NFWD+1)
)(
   input  logic [REGW-1:0]      src,
   input  logic                 src_used,
   input  logic [NFWD*REGW-1:0] dst_stage,
   input  logic [NFWD-1:0]      wr_stage,
   output logic [SELW-1:0]      sel
);

   // Scan oldest to youngest so the lowest matching stage overwrites the rest
   always_comb begin
      sel = SELW'(FHC_SEL_RF);
      for (int k = NFWD-1; k >= 0; k--) begin
         if (wr_stage[k] && src_used &&
             (dst_stage[k*REGW +: REGW] != '0) &&
             (dst_stage[k*REGW +: REGW] == src))
            sel = SELW'(k+1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl
// Brief  : Operand bypass select, load-use bubble and D-cache miss freeze.
//          Optional statistics counters: define FWD_HAZARD_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int NSRC         = 2,
   parameter int NFWD         = 2,
   parameter int REGW         = 5,
   parameter int SELW         = $clog2(NFWD+1),
   parameter int MISS_TIMEOUT = 255,
   parameter int CNTW         = 32
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NSRC*REGW-1:0] src_ex,
   input  logic [NSRC-1:0]      src_used_ex,
   input  logic [NSRC*REGW-1:0] src_id,
   input  logic [NSRC-1:0]      src_used_id,
   input  logic [NFWD*REGW-1:0] dst_stage,
   input  logic [NFWD-1:0]      wr_stage,
   input  logic                 memrd_ex,
   input  logic [REGW-1:0]      dst_ex,
   input  logic                 dmem_wait,
   output logic [NSRC*SELW-1:0] fwd_sel,
   output logic                 stall_if_id,
   output logic                 bubble_id_ex,
   output logic                 freeze_all,
   output logic                 miss_timeout,
   output logic [CNTW-1:0]      fwd_count,
   output logic [CNTW-1:0]      lu_count,
   output logic [CNTW-1:0]      miss_count
);

   localparam int             c_mcw      = $clog2(MISS_TIMEOUT+1);
   localparam logic [c_mcw-1:0] c_miss_max = c_mcw'(MISS_TIMEOUT);

   fhc_state_t             r_state, w_next_state;
   logic [NSRC*SELW-1:0]   w_live_sel;
   logic [NSRC*SELW-1:0]   r_hold;
   logic [c_mcw-1:0]       r_miss_cnt;
   logic [c_mcw-1:0]       w_miss_cnt_nxt;
   logic                   r_timeout;
   logic                   w_lu_hazard;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      fwd_select #(
         .NFWD (NFWD),
         .REGW (REGW),
         .SELW (SELW)
      ) u_fwd_select (
         .src       (src_ex[gi*REGW +: REGW]),
         .src_used  (src_used_ex[gi]),
         .dst_stage (dst_stage),
         .wr_stage  (wr_stage),
         .sel       (w_live_sel[gi*SELW +: SELW])
      );
   end

   always_comb begin
      w_lu_hazard = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (src_used_id[i] && (src_id[i*REGW +: REGW] == dst_ex))
            w_lu_hazard = 1'b1;
      end
      if (!memrd_ex || (dst_ex == '0))
         w_lu_hazard = 1'b0;
   end

   always_comb begin
      w_next_state = r_state;
      fwd_sel      = w_live_sel;
      stall_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      freeze_all   = 1'b0;
      case (r_state)
         RUN, RESUME: begin
            freeze_all = dmem_wait;
            if (w_lu_hazard && !dmem_wait) begin
               stall_if_id  = 1'b1;
               bubble_id_ex = 1'b1;
            end
            w_next_state = dmem_wait ? MISS : RUN;
         end
         MISS: begin
            // Bypass selects are frozen with the latches they feed
            freeze_all = 1'b1;
            fwd_sel    = r_hold;
            if (!dmem_wait)
               w_next_state = RESUME;
         end
         default: w_next_state = RUN;
      endcase
   end

   assign w_miss_cnt_nxt = (r_miss_cnt == c_miss_max) ? r_miss_cnt
                                                       : r_miss_cnt + c_mcw'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= RUN;
         r_hold     <= '0;
         r_miss_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if ((r_state != MISS) && dmem_wait)
            r_hold <= w_live_sel;
         if (r_state == MISS) begin
            r_miss_cnt <= dmem_wait ? w_miss_cnt_nxt : '0;
            if (w_miss_cnt_nxt == c_miss_max)
               r_timeout <= 1'b1;
         end
      end
   end

   assign miss_timeout = r_timeout;

`ifdef FWD_HAZARD_STATS_EN
   logic [CNTW-1:0] r_fwd_cnt, r_lu_cnt, r_miss_stat;
   logic            w_any_fwd;

   assign w_any_fwd = |fwd_sel;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fwd_cnt   <= '0;
         r_lu_cnt    <= '0;
         r_miss_stat <= '0;
      end else begin
         if (w_any_fwd && !freeze_all && !(&r_fwd_cnt))
            r_fwd_cnt <= r_fwd_cnt + CNTW'(1);
         if (bubble_id_ex && !(&r_lu_cnt))
            r_lu_cnt <= r_lu_cnt + CNTW'(1);
         if ((r_state == MISS) && !(&r_miss_stat))
            r_miss_stat <= r_miss_stat + CNTW'(1);
      end
   end

   assign fwd_count  = r_fwd_cnt;
   assign lu_count   = r_lu_cnt;
   assign miss_count = r_miss_stat;
`else
   assign fwd_count  = '0;
   assign lu_count   = '0;
   assign miss_count = '0;
`endif

endmodule
`default_nettype wire
